// File: rtl/sat_span_accum_if.sv
// rtl/sat_span_accum_if.sv - command and pixel-stream bundle for sat_span_accum
//
// Purpose : groups the span command inputs, the valid/ready pixel stream and
//           the status flags of sat_span_accum into one interface.
// Ports   : start, init[15:0], step[15:0], count[CNT_W-1:0], sat, eightbit
//           (command, driven by master); out_valid, out_data[15:0] (pixel
//           stream, driven by slave); out_ready (driven by master);
//           busy, done (status, driven by slave).
//           frac_init[7:0], frac_step[7:0] exist only with SPAN_ACCUM_FRAC_EN.
// Modports: master = span requester / pixel writer side, slave = the stepper.

interface sat_span_accum_if #(
   parameter int CNT_W = 10
) ();

   logic             start;
   logic [15:0]      init;
   logic [15:0]      step;
   logic [CNT_W-1:0] count;
   logic             sat;
   logic             eightbit;
`ifdef SPAN_ACCUM_FRAC_EN
   logic [7:0]       frac_init;
   logic [7:0]       frac_step;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [15:0]      out_data;
   logic             busy;
   logic             done;

   modport master (
`ifdef SPAN_ACCUM_FRAC_EN
      output frac_init, frac_step,
`endif
      output start, init, step, count, sat, eightbit, out_ready,
      input  out_valid, out_data, busy, done
   );

   modport slave (
`ifdef SPAN_ACCUM_FRAC_EN
      input  frac_init, frac_step,
`endif
      input  start, init, step, count, sat, eightbit, out_ready,
      output out_valid, out_data, busy, done
   );

endinterface

// File: rtl/sat_span_accum.sv
// rtl/sat_span_accum.sv - sequential saturating span stepper, one pixel per accepted handshake
//
// Purpose : emits v[k] = init + k*step for k = 0..count-1, stepping one
//           saturating (or wrapping) add per accepted pixel. 16-bit mode or
//           low-byte-only mode (high byte wraps independently, no carry
//           from bit 7 into bit 8). All outputs are registered; there is no
//           combinational path from any input to any output.
// Ports   : clk     - rising-edge clock
//           resetl  - asynchronous active-low reset
//           bus     - sat_span_accum_if.slave: command (start/init/step/count/
//                     sat/eightbit), pixel stream (out_valid/out_ready/
//                     out_data), status (busy/done)
// Config  : SPAN_ACCUM_FRAC_EN - adds an 8-bit fraction accumulator whose
//           carry feeds the integer add (frac_init/frac_step interface ports).

module sat_span_accum #(
   parameter int CNT_W = 10
) (
   input  logic              clk,
   input  logic              resetl,
   sat_span_accum_if.slave   bus
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t           state;
   logic [15:0]      acc;
   logic [15:0]      step_q;
   logic [CNT_W-1:0] remaining;
   logic             sat_q;
   logic             eightbit_q;
   logic             out_valid_q;
   logic             busy_q;
   logic             done_q;

   // next-value datapath
   logic [15:0]      acc_next;
   logic             cin;
   logic [16:0]      sum16;
   logic [8:0]       sum_lo;
   logic [7:0]       sum_hi;
   logic             ovf;
   logic             sat_high;
   logic             sat_fire;
   logic             handshake;

`ifdef SPAN_ACCUM_FRAC_EN
   logic [7:0]       frac_q;
   logic [7:0]       frac_step_q;
   logic [8:0]       frac_sum;
   logic [7:0]       frac_next;
`endif

   assign handshake = out_valid_q & bus.out_ready;

   // satadd(acc, step_q) with optional fractional carry-in.
   // Overflow is detected as (sign of step) XOR (carry out of the active
   // width): a positive step that carries has gone past the top, a negative
   // step that fails to carry has gone below zero. The carry itself tells
   // which rail to pin to.
   always_comb begin
      cin       = 1'b0;
`ifdef SPAN_ACCUM_FRAC_EN
      frac_sum  = {1'b0, frac_q} + {1'b0, frac_step_q};
      cin       = frac_sum[8];
      frac_next = frac_sum[7:0];
`endif
      sum16    = {1'b0, acc} + {1'b0, step_q} + {16'd0, cin};
      sum_lo   = {1'b0, acc[7:0]} + {1'b0, step_q[7:0]} + {8'd0, cin};
      sum_hi   = acc[15:8] + step_q[15:8];
      acc_next = sum16[15:0];
      ovf      = 1'b0;
      sat_high = 1'b0;
      if (eightbit_q) begin
         // Byte lanes are split: the high byte never sees the low carry
         // and is never saturated.
         ovf      = step_q[7] ^ sum_lo[8];
         sat_high = sum_lo[8];
         acc_next = {sum_hi, sum_lo[7:0]};
      end else begin
         ovf      = step_q[15] ^ sum16[16];
         sat_high = sum16[16];
      end
      sat_fire = sat_q & ovf;
      if (sat_fire) begin
         if (eightbit_q) begin
            acc_next[7:0] = {8{sat_high}};
         end else begin
            acc_next = {16{sat_high}};
         end
      end
`ifdef SPAN_ACCUM_FRAC_EN
      // A pinned integer part drags the fraction to the same rail so the
      // combined fixed-point value is exactly full-scale or zero.
      if (sat_fire) begin
         frac_next = {8{sat_high}};
      end
`endif
   end

   always_ff @(posedge clk or negedge resetl) begin
      if (!resetl) begin
         state       <= S_IDLE;
         acc         <= 16'd0;
         step_q      <= 16'd0;
         remaining   <= '0;
         sat_q       <= 1'b0;
         eightbit_q  <= 1'b0;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef SPAN_ACCUM_FRAC_EN
         frac_q      <= 8'd0;
         frac_step_q <= 8'd0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  if (bus.count != '0) begin
                     acc         <= bus.init;
                     step_q      <= bus.step;
                     remaining   <= bus.count;
                     sat_q       <= bus.sat;
                     eightbit_q  <= bus.eightbit;
`ifdef SPAN_ACCUM_FRAC_EN
                     frac_q      <= bus.frac_init;
                     frac_step_q <= bus.frac_step;
`endif
                     out_valid_q <= 1'b1;
                     busy_q      <= 1'b1;
                     state       <= S_RUN;
                  end else begin
                     // Empty span: acknowledge with done, emit nothing.
                     done_q <= 1'b1;
                  end
               end
            end
            S_RUN: begin
               if (handshake) begin
                  acc       <= acc_next;
`ifdef SPAN_ACCUM_FRAC_EN
                  frac_q    <= frac_next;
`endif
                  remaining <= remaining - 1'b1;
                  if (remaining == {{(CNT_W-1){1'b0}}, 1'b1}) begin
                     out_valid_q <= 1'b0;
                     busy_q      <= 1'b0;
                     done_q      <= 1'b1;
                     state       <= S_IDLE;
                  end
               end
            end
            default: begin
               state       <= S_IDLE;
               out_valid_q <= 1'b0;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = acc;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;

endmodule

// File: tb/tb_sat_span_accum.sv
// tb/tb_sat_span_accum.sv - table-driven scoreboard bench for sat_span_accum

module tb_sat_span_accum;

   logic clk = 1'b0;
   logic resetl;

   always #5 clk = ~clk;

   sat_span_accum_if #(.CNT_W(10)) bus ();

   sat_span_accum #(.CNT_W(10)) dut (
      .clk    (clk),
      .resetl (resetl),
      .bus    (bus)
   );

   typedef struct {
      logic [15:0] init;
      logic [15:0] step;
      logic [9:0]  count;
      logic        sat;
      logic        eightbit;
      logic        rnd;
      logic [15:0] exp [4];
   } vec_t;

   int checks = 0;
   int passed = 0;
   int acc_cnt = 0;
   int done_cnt = 0;
   logic [15:0] exp_q [$];
   logic        stall_prev = 1'b0;
   logic [15:0] stall_data = 16'd0;
   vec_t        vecs [10];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s actual=%h expected=%h", nm, act, exp);
   endtask

   function automatic vec_t mk(input logic [15:0] init, input logic [15:0] step,
                               input logic [9:0] count, input logic sat,
                               input logic eightbit, input logic rnd,
                               input logic [15:0] e0, input logic [15:0] e1,
                               input logic [15:0] e2, input logic [15:0] e3);
      vec_t v;
      v.init = init; v.step = step; v.count = count;
      v.sat = sat; v.eightbit = eightbit; v.rnd = rnd;
      v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3;
      return v;
   endfunction

   // Scoreboard monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (!resetl) begin
         exp_q.delete();
         stall_prev = 1'b0;
      end else begin
         if (stall_prev) begin
            check("stall_valid_hold", {31'd0, bus.out_valid}, 32'd1);
            check("stall_data_hold", {16'd0, bus.out_data}, {16'd0, stall_data});
         end
         if (bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
               check("pixel_unexpected", 32'(exp_q.size()), 32'd1);
            end else begin
               check("pixel", {16'd0, bus.out_data}, {16'd0, exp_q.pop_front()});
            end
            acc_cnt++;
         end
         stall_prev = bus.out_valid && !bus.out_ready;
         stall_data = bus.out_data;
         if (bus.done) done_cnt++;
      end
   end

   task automatic drive_start(input logic [15:0] init, input logic [15:0] step,
                              input logic [9:0] count, input logic sat, input logic eb);
      bus.start = 1'b1; bus.init = init; bus.step = step;
      bus.count = count; bus.sat = sat; bus.eightbit = eb;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   task automatic run_span(input vec_t v);
      int a0, d0, cyc;
      for (int i = 0; i < int'(v.count); i++) exp_q.push_back(v.exp[i]);
      drive_start(v.init, v.step, v.count, v.sat, v.eightbit);
      check("first_valid", {31'd0, bus.out_valid}, 32'd1);
      check("first_data", {16'd0, bus.out_data}, {16'd0, v.exp[0]});
      a0 = acc_cnt; d0 = done_cnt; cyc = 0;
      while (done_cnt == d0 && cyc < 200) begin
         bus.out_ready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(posedge clk); #1;
         cyc++;
      end
      check("done_seen", 32'(done_cnt - d0), 32'd1);
      check("accept_count", 32'(acc_cnt - a0), 32'(v.count));
      check("queue_empty", 32'(exp_q.size()), 32'd0);
      check("idle_after_done", {30'd0, bus.busy, bus.out_valid}, 32'd0);
      check("done_single", {31'd0, bus.done}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int a0, d0;
      resetl = 1'b0;
      bus.start = 1'b0; bus.init = 16'd0; bus.step = 16'd0; bus.count = 10'd0;
      bus.sat = 1'b0; bus.eightbit = 1'b0; bus.out_ready = 1'b0;
`ifdef SPAN_ACCUM_FRAC_EN
      bus.frac_init = 8'd0; bus.frac_step = 8'd0;
`endif
      vecs[0] = mk(16'hFFF0, 16'h0008, 10'd4, 1, 0, 0, 16'hFFF0, 16'hFFF8, 16'hFFFF, 16'hFFFF);
      vecs[1] = mk(16'h0010, 16'hFFF8, 10'd4, 1, 0, 0, 16'h0010, 16'h0008, 16'h0000, 16'h0000);
      vecs[2] = mk(16'h0010, 16'hFFF8, 10'd4, 0, 0, 1, 16'h0010, 16'h0008, 16'h0000, 16'hFFF8);
      vecs[3] = mk(16'h12F0, 16'h0008, 10'd4, 1, 1, 0, 16'h12F0, 16'h12F8, 16'h12FF, 16'h12FF);
      vecs[4] = mk(16'hFFF0, 16'h0008, 10'd4, 0, 0, 1, 16'hFFF0, 16'hFFF8, 16'h0000, 16'h0008);
      vecs[5] = mk(16'h01F8, 16'h0108, 10'd3, 0, 1, 0, 16'h01F8, 16'h0200, 16'h0308, 16'h0000);
      vecs[6] = mk(16'h01F8, 16'h0108, 10'd3, 1, 1, 1, 16'h01F8, 16'h02FF, 16'h03FF, 16'h0000);
      vecs[7] = mk(16'h0505, 16'h00FC, 10'd3, 1, 1, 0, 16'h0505, 16'h0501, 16'h0500, 16'h0000);
      vecs[8] = mk(16'h0000, 16'h8000, 10'd3, 1, 0, 1, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      vecs[9] = mk(16'h7FFF, 16'h7FFF, 10'd3, 1, 0, 0, 16'h7FFF, 16'hFFFE, 16'hFFFF, 16'h0000);

      repeat (2) @(posedge clk);
      #1;
      check("reset_valid", {31'd0, bus.out_valid}, 32'd0);
      check("reset_data", {16'd0, bus.out_data}, 32'd0);
      check("reset_busy", {31'd0, bus.busy}, 32'd0);
      check("reset_done", {31'd0, bus.done}, 32'd0);
      resetl = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++) run_span(vecs[i]);

      // Stall pattern: ready 1,0,0,1,0,1 with three pixels.
      begin
         logic [5:0] pat;
         pat = 6'b101001;
         exp_q.push_back(16'h0100); exp_q.push_back(16'h0101); exp_q.push_back(16'h0102);
         a0 = acc_cnt; d0 = done_cnt;
         drive_start(16'h0100, 16'h0001, 10'd3, 1'b1, 1'b0);
         for (int i = 0; i < 6; i++) begin
            bus.out_ready = pat[i];
            @(posedge clk); #1;
         end
         check("stall_done", {31'd0, bus.done}, 32'd1);
         check("stall_accepts", 32'(acc_cnt - a0), 32'd3);
         check("stall_queue", 32'(exp_q.size()), 32'd0);
      end

      // Zero-length span.
      bus.out_ready = 1'b1;
      d0 = done_cnt;
      drive_start(16'h5555, 16'h0001, 10'd0, 1'b0, 1'b0);
      check("zero_done", {31'd0, bus.done}, 32'd1);
      check("zero_valid", {31'd0, bus.out_valid}, 32'd0);
      check("zero_busy", {31'd0, bus.busy}, 32'd0);
      @(posedge clk); #1;
      check("zero_done_pulse", {31'd0, bus.done}, 32'd0);
      check("zero_valid_after", {31'd0, bus.out_valid}, 32'd0);

      // Start arriving in the cycle of the final handshake is ignored.
      exp_q.push_back(16'h0200); exp_q.push_back(16'h0201);
      d0 = done_cnt;
      drive_start(16'h0200, 16'h0001, 10'd2, 1'b0, 1'b0);
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.init = 16'h9999; bus.count = 10'd2;
      @(posedge clk); #1;
      bus.start = 1'b0;
      check("collide_done", {31'd0, bus.done}, 32'd1);
      check("collide_idle", {30'd0, bus.busy, bus.out_valid}, 32'd0);
      @(posedge clk); #1;
      check("collide_not_started", {30'd0, bus.busy, bus.out_valid}, 32'd0);
      check("collide_queue", 32'(exp_q.size()), 32'd0);

      // Asynchronous reset while pixel 2 of 5 is presented.
      exp_q.push_back(16'h1000); exp_q.push_back(16'h1010); exp_q.push_back(16'h1020);
      exp_q.push_back(16'h1030); exp_q.push_back(16'h1040);
      d0 = done_cnt;
      drive_start(16'h1000, 16'h0010, 10'd5, 1'b1, 1'b0);
      @(posedge clk); #1;
      check("mid_pixel2", {16'd0, bus.out_data}, 32'h1010);
      #2 resetl = 1'b0;
      #1;
      check("abort_valid", {31'd0, bus.out_valid}, 32'd0);
      check("abort_data", {16'd0, bus.out_data}, 32'd0);
      check("abort_busy", {31'd0, bus.busy}, 32'd0);
      check("abort_done", {31'd0, bus.done}, 32'd0);
      @(posedge clk); #1;
      resetl = 1'b1;
      @(posedge clk); #1;
      check("abort_no_done", 32'(done_cnt - d0), 32'd0);
      run_span(mk(16'h0ABC, 16'h0001, 10'd2, 0, 0, 0, 16'h0ABC, 16'h0ABD, 16'h0000, 16'h0000));

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
